// File: rtl/seq_alu.sv
// Clocked execute-stage ALU: valid/ready operand intake, internal Z/N/C flags, iterative shifts.
// Define SEQ_ALU_MUL_EN to build in the iterative shift-add multiplier (opcode 29).
module seq_alu #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rd,
    input  logic             ccr_load,
    input  logic [2:0]       ccr_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       ccr,
    output logic             jump
);

    localparam logic [4:0] OP_NOT  = 5'd1;
    localparam logic [4:0] OP_SETC = 5'd2;
    localparam logic [4:0] OP_CLRC = 5'd3;
    localparam logic [4:0] OP_INC  = 5'd4;
    localparam logic [4:0] OP_DEC  = 5'd5;
    localparam logic [4:0] OP_OUT  = 5'd6;
    localparam logic [4:0] OP_IN   = 5'd7;
    localparam logic [4:0] OP_MOV  = 5'd8;
    localparam logic [4:0] OP_ADD  = 5'd9;
    localparam logic [4:0] OP_SUB  = 5'd10;
    localparam logic [4:0] OP_AND  = 5'd11;
    localparam logic [4:0] OP_OR   = 5'd12;
    localparam logic [4:0] OP_SHL  = 5'd13;
    localparam logic [4:0] OP_SHR  = 5'd14;
    localparam logic [4:0] OP_PUSH = 5'd15;
    localparam logic [4:0] OP_LDM  = 5'd17;
    localparam logic [4:0] OP_LDD  = 5'd18;
    localparam logic [4:0] OP_STD  = 5'd19;
    localparam logic [4:0] OP_JZ   = 5'd20;
    localparam logic [4:0] OP_JN   = 5'd21;
    localparam logic [4:0] OP_JC   = 5'd22;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'd29;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             shLeft;

    logic [WIDTH:0]   addRes;
    logic [WIDTH:0]   subRes;
    logic [WIDTH:0]   incRes;
    logic [WIDTH:0]   decRes;
    logic [WIDTH-1:0] shNext;
    logic             shBit;
    logic [SHW-1:0]   shAmt;

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] mulHi;
    logic [WIDTH-1:0] mulCand;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] mulHiNext;
    logic [WIDTH-1:0] mulLoNext;
`endif

    // {N, Z} of a WIDTH-bit result
    function automatic logic [1:0] zn(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], r == '0};
    endfunction

    assign in_ready = (state == IDLE);

    always_comb begin
        addRes = {1'b0, rd} + {1'b0, rs};
        subRes = {1'b0, rd} - {1'b0, rs};
        incRes = {1'b0, rd} + (WIDTH+1)'(1);
        decRes = {1'b0, rd} - (WIDTH+1)'(1);
        shAmt  = rd[SHW-1:0];
        shNext = shLeft ? {work[WIDTH-2:0], 1'b0} : {1'b0, work[WIDTH-1:1]};
        shBit  = shLeft ? work[WIDTH-1] : work[0];
    end

`ifdef SEQ_ALU_MUL_EN
    // One shift-add step: {carry, hi, lo} >> 1 after conditionally adding the multiplicand
    always_comb begin
        mulSum    = {1'b0, mulHi} + (work[0] ? {1'b0, mulCand} : '0);
        mulHiNext = mulSum[WIDTH:1];
        mulLoNext = {mulSum[0], work[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            jump      <= 1'b0;
            ccr       <= 3'b000;
            work      <= '0;
            cnt       <= '0;
            shLeft    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mulHi     <= '0;
            mulCand   <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            jump      <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_valid <= 1'b1;
                        case (alu_op)
                            OP_NOT: begin
                                out      <= ~rd;
                                ccr[1:0] <= zn(~rd);
                            end
                            OP_SETC: begin
                                out    <= '0;
                                ccr[2] <= 1'b1;
                            end
                            OP_CLRC: begin
                                out    <= '0;
                                ccr[2] <= 1'b0;
                            end
                            OP_INC: begin
                                out <= incRes[WIDTH-1:0];
                                ccr <= {incRes[WIDTH], zn(incRes[WIDTH-1:0])};
                            end
                            OP_DEC: begin
                                out <= decRes[WIDTH-1:0];
                                ccr <= {decRes[WIDTH], zn(decRes[WIDTH-1:0])};
                            end
                            OP_OUT, OP_IN, OP_PUSH, OP_LDM: out <= rd;
                            OP_MOV, OP_LDD, OP_STD:         out <= rs;
                            OP_ADD: begin
                                out <= addRes[WIDTH-1:0];
                                ccr <= {addRes[WIDTH], zn(addRes[WIDTH-1:0])};
                            end
                            OP_SUB: begin
                                out <= subRes[WIDTH-1:0];
                                ccr <= {subRes[WIDTH], zn(subRes[WIDTH-1:0])};
                            end
                            OP_AND: begin
                                out      <= rd & rs;
                                ccr[1:0] <= zn(rd & rs);
                            end
                            OP_OR: begin
                                out      <= rd | rs;
                                ccr[1:0] <= zn(rd | rs);
                            end
                            OP_SHL, OP_SHR: begin
                                if (shAmt == '0) begin
                                    out <= rs;
                                end else begin
                                    out_valid <= 1'b0;
                                    work      <= rs;
                                    cnt       <= shAmt;
                                    shLeft    <= (alu_op == OP_SHL);
                                    state     <= SHIFT;
                                end
                            end
                            OP_JZ, OP_JN, OP_JC: begin
                                // Taken branch consumes the flag it tested
                                out <= '0;
                                if (ccr[alu_op[1:0]]) begin
                                    jump              <= 1'b1;
                                    ccr[alu_op[1:0]] <= 1'b0;
                                end
                            end
`ifdef SEQ_ALU_MUL_EN
                            OP_MUL: begin
                                out_valid <= 1'b0;
                                work      <= rs;
                                mulHi     <= '0;
                                mulCand   <= rd;
                                cnt       <= SHW'(WIDTH - 1);
                                state     <= MUL;
                            end
`endif
                            default: out <= '0;
                        endcase
                    end
                end
                SHIFT: begin
                    work   <= shNext;
                    ccr[2] <= shBit;
                    cnt    <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        out       <= shNext;
                        ccr[1:0]  <= zn(shNext);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                MUL: begin
                    work  <= mulLoNext;
                    mulHi <= mulHiNext;
                    cnt   <= cnt - SHW'(1);
                    if (cnt == '0) begin
                        out       <= mulLoNext;
                        ccr       <= {|mulHiNext, zn(mulLoNext)};
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
            // Flag restore overrides any flag update landing on the same edge
            if (ccr_load) ccr <= ccr_in;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus randomized ops against a behavioural model.
module tb_seq_alu;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   alu_op;
    logic [W-1:0] rs;
    logic [W-1:0] rd;
    logic         ccr_load;
    logic [2:0]   ccr_in;
    logic         out_valid;
    logic [W-1:0] out;
    logic [2:0]   ccr;
    logic         jump;

    int total = 0;
    int bad   = 0;
    logic [2:0] mCcr;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .rs(rs), .rd(rd), .ccr_load(ccr_load), .ccr_in(ccr_in),
        .out_valid(out_valid), .out(out), .ccr(ccr), .jump(jump)
    );

    always #5 clk = ~clk;

    // Expected result of one op from the instruction-set rules (a=rs, b=rd)
    task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] cIn, output logic [W-1:0] r, output logic [2:0] c,
                         output logic j, output int lat, output bit known);
        longint unsigned wide;
        int k;
        int idx;
        bit upd;
        r = '0; c = cIn; j = 1'b0; lat = 0; known = 1'b1; upd = 1'b0;
        k = int'(b[3:0]);
        case (op)
            5'd1:  begin r = ~b; upd = 1'b1; end
            5'd2:  begin c[2] = 1'b1; known = 1'b0; end
            5'd3:  begin c[2] = 1'b0; known = 1'b0; end
            5'd4:  begin wide = 64'(b) + 64'd1; r = wide[15:0]; c[2] = wide[16]; upd = 1'b1; end
            5'd5:  begin r = b - 16'd1; c[2] = (b == 16'd0); upd = 1'b1; end
            5'd6, 5'd7, 5'd15, 5'd17: r = b;
            5'd8, 5'd18, 5'd19: r = a;
            5'd9:  begin wide = 64'(a) + 64'(b); r = wide[15:0]; c[2] = wide[16]; upd = 1'b1; end
            5'd10: begin r = b - a; c[2] = (a > b); upd = 1'b1; end
            5'd11: begin r = a & b; upd = 1'b1; end
            5'd12: begin r = a | b; upd = 1'b1; end
            5'd13, 5'd14: begin
                if (k == 0) r = a;
                else begin
                    lat = k; upd = 1'b1;
                    if (op == 5'd13) begin r = a << k; c[2] = a[W-k]; end
                    else begin r = a >> k; c[2] = a[k-1]; end
                end
            end
            5'd20, 5'd21, 5'd22: begin
                idx = int'(op) - 20;
                if (c[idx]) begin j = 1'b1; c[idx] = 1'b0; end
            end
`ifdef SEQ_ALU_MUL_EN
            5'd29: begin
                wide = 64'(a) * 64'(b); r = wide[15:0]; c[2] = (wide[31:16] != 0);
                upd = 1'b1; lat = W;
            end
`endif
            default: r = '0;
        endcase
        if (upd) begin c[0] = (r == '0); c[1] = r[W-1]; end
    endtask

    // Issue one op, wait its latency, and return what the DUT shows in the result cycle
    task automatic runOp(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic load, input logic [2:0] lv, input int lat,
                         output logic [W-1:0] oOut, output logic [2:0] oCcr, output logic oJump,
                         output logic oValid, output int stall);
        int guard = 0;
        stall = 0;
        while (in_ready !== 1'b1 && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        alu_op = op; rs = a; rd = b; ccr_load = load; ccr_in = lv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; ccr_load = 1'b0;
        rs = W'($urandom); rd = W'($urandom); alu_op = 5'($urandom);
        for (int i = 0; i < lat; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || jump !== 1'b0) stall++;
            @(posedge clk); #1;
        end
        oOut = out; oCcr = ccr; oJump = jump; oValid = out_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; ccr_load = 1'b0; ccr_in = '0; alu_op = '0; rs = '0; rd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total++; if (out !== '0) begin bad++; $display("FAIL reset_out: got %h want 0000", out); end
        total++; if (ccr !== 3'b000) begin bad++; $display("FAIL reset_ccr: got %b want 000", ccr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        total++; if (jump !== 1'b0) begin bad++; $display("FAIL reset_jump: got %b want 0", jump); end
        mCcr = 3'b000;
    endtask

    task automatic test_add_jump;
        logic [W-1:0] o; logic [2:0] c; logic j, v; int s;
        runOp(5'd9, 16'h0001, 16'hFFFF, 1'b0, 3'b000, 0, o, c, j, v, s);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", v); end
        total++; if (o !== 16'h0000) begin bad++; $display("FAIL add_out: got %h want 0000", o); end
        total++; if (c !== 3'b101) begin bad++; $display("FAIL add_ccr: got %b want 101", c); end
        runOp(5'd22, 16'h1234, 16'h5678, 1'b0, 3'b000, 0, o, c, j, v, s);
        total++; if (v !== 1'b1 || j !== 1'b1) begin bad++; $display("FAIL jc_taken: valid %b jump %b want 1 1", v, j); end
        total++; if (c !== 3'b001) begin bad++; $display("FAIL jc_ccr: got %b want 001", c); end
        total++; if (o !== 16'h0000) begin bad++; $display("FAIL jc_out: got %h want 0000", o); end
    endtask

    task automatic test_sub_jump;
        logic [W-1:0] o; logic [2:0] c; logic j, v; int s;
        runOp(5'd10, 16'h0007, 16'h0005, 1'b0, 3'b000, 0, o, c, j, v, s);
        total++; if (o !== 16'hFFFE) begin bad++; $display("FAIL sub_out: got %h want fffe", o); end
        total++; if (c !== 3'b110) begin bad++; $display("FAIL sub_ccr: got %b want 110", c); end
        runOp(5'd20, 16'h0000, 16'h0000, 1'b0, 3'b000, 0, o, c, j, v, s);
        total++; if (v !== 1'b1 || j !== 1'b0) begin bad++; $display("FAIL jz_not_taken: valid %b jump %b want 1 0", v, j); end
        total++; if (c !== 3'b110) begin bad++; $display("FAIL jz_ccr: got %b want 110", c); end
    endtask

    task automatic test_shift;
        logic [W-1:0] o; logic [2:0] c; logic j, v; int s;
        runOp(5'd13, 16'h8001, 16'h0003, 1'b0, 3'b000, 3, o, c, j, v, s);
        total++; if (s !== 0) begin bad++; $display("FAIL shl_busy: %0d bad wait cycles want 0", s); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL shl_valid: got %b want 1", v); end
        total++; if (o !== 16'h0008) begin bad++; $display("FAIL shl_out: got %h want 0008", o); end
        total++; if (c !== 3'b000) begin bad++; $display("FAIL shl_ccr: got %b want 000", c); end
        runOp(5'd14, 16'h0005, 16'h0001, 1'b0, 3'b000, 1, o, c, j, v, s);
        total++; if (v !== 1'b1 || s !== 0) begin bad++; $display("FAIL shr_timing: valid %b stalls %0d want 1 0", v, s); end
        total++; if (o !== 16'h0002) begin bad++; $display("FAIL shr_out: got %h want 0002", o); end
        total++; if (c !== 3'b100) begin bad++; $display("FAIL shr_ccr: got %b want 100", c); end
        mCcr = 3'b100;
    endtask

    task automatic test_reset_abort;
        int seen = 0;
        alu_op = 5'd13; rs = W'($urandom); rd = 16'h0004; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", in_ready); end
        total++; if (ccr !== 3'b000 || out !== '0) begin bad++; $display("FAIL abort_state: ccr %b out %h want 000 0000", ccr, out); end
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_pulse: %0d pulses want 0", seen); end
        mCcr = 3'b000;
    endtask

    task automatic test_ccr_load;
        logic [W-1:0] o; logic [2:0] c; logic j, v; int s;
        runOp(5'd11, 16'h0F00, 16'h00F0, 1'b1, 3'b110, 0, o, c, j, v, s);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL ld_valid: got %b want 1", v); end
        total++; if (o !== 16'h0000) begin bad++; $display("FAIL ld_out: got %h want 0000", o); end
        total++; if (c !== 3'b110) begin bad++; $display("FAIL ld_ccr: got %b want 110", c); end
        mCcr = 3'b110;
    endtask

    task automatic test_mul;
        logic [W-1:0] o; logic [2:0] c; logic j, v; int s;
`ifdef SEQ_ALU_MUL_EN
        runOp(5'd29, 16'h0100, 16'h0100, 1'b0, 3'b000, 16, o, c, j, v, s);
        total++; if (v !== 1'b1 || s !== 0) begin bad++; $display("FAIL mul_timing: valid %b stalls %0d want 1 0", v, s); end
        total++; if (o !== 16'h0000) begin bad++; $display("FAIL mul_out: got %h want 0000", o); end
        total++; if (c !== 3'b101) begin bad++; $display("FAIL mul_ccr: got %b want 101", c); end
        mCcr = 3'b101;
`else
        runOp(5'd29, 16'h0100, 16'h0100, 1'b0, 3'b000, 0, o, c, j, v, s);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL op29_valid: got %b want 1", v); end
        total++; if (o !== 16'h0000) begin bad++; $display("FAIL op29_out: got %h want 0000", o); end
        total++; if (c !== mCcr) begin bad++; $display("FAIL op29_ccr: got %b want %b", c, mCcr); end
`endif
    endtask

    // Random ops issued back to back, including multi-cycle ones and flag restores
    task automatic test_random;
        logic [W-1:0] a, b, eOut, o;
        logic [2:0] eCcr, lv, c;
        logic eJ, j, v, load;
        logic [4:0] op;
        int lat, s;
        bit known;
        for (int n = 0; n < 250; n++) begin
            op = 5'($urandom_range(0, 31));
            a = W'($urandom); b = W'($urandom);
            if (n % 5 == 0) b[3:0] = 4'($urandom_range(0, 2));
            load = ($urandom_range(0, 7) == 0);
            lv = 3'($urandom);
            model(op, a, b, mCcr, eOut, eCcr, eJ, lat, known);
            if (load) begin
                if (lat == 0) eCcr = lv;
                else model(op, a, b, lv, eOut, eCcr, eJ, lat, known);
            end
            runOp(op, a, b, load, lv, lat, o, c, j, v, s);
            total++; if (v !== 1'b1 || s !== 0) begin bad++; $display("FAIL rnd_timing op=%0d: valid %b stalls %0d want 1 0", op, v, s); end
            if (known) begin
                total++; if (o !== eOut) begin bad++; $display("FAIL rnd_out op=%0d rs=%h rd=%h: got %h want %h", op, a, b, o, eOut); end
            end
            total++; if (c !== eCcr) begin bad++; $display("FAIL rnd_ccr op=%0d rs=%h rd=%h: got %b want %b", op, a, b, c, eCcr); end
            total++; if (j !== eJ) begin bad++; $display("FAIL rnd_jump op=%0d: got %b want %b", op, j, eJ); end
            mCcr = eCcr;
        end
    endtask

    initial begin
        test_reset();
        test_add_jump();
        test_sub_jump();
        test_shift();
        test_reset_abort();
        test_ccr_load();
        test_mul();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
